sonata_switch_debounce: RTL
===========================

Name: sonata_switch_debounce

Overview:
- Input conditioner for the board's active-low, pulled-up user and navigation switches. It is the read side of the general-purpose input path.
- Per bit, it synchronises the raw pin into clk_sys_i, debounces it with a consecutive-sample counter and inverts it, so 1 means pressed.
- It also produces single-cycle edge pulses and a sticky, maskable interrupt.
- It sits between the top-level switch pins and the demo system's gp_i and interrupt inputs.

Parameters:
- Width, 13, number of switch bits (bits 12:5 user_sw, bits 4:0 nav_sw).
- DebounceCycles, 500000, consecutive stable samples required before the output changes (10 ms at 50 MHz); legal range >= 2.
- CntWidth, $clog2(DebounceCycles), width of each per-bit counter (derived; do not override).

Ports:
- clk_sys_i  input  1  system clock.
- rst_sys_ni  input  1  reset, asynchronous, active-low.
- sw_ni  input  Width  raw switch pins, active-low, asynchronous to clk_sys_i.
- irq_en_i  input  Width  per-bit interrupt enable.
- clr_i  input  Width  per-bit write-1-to-clear of the status register; level-sampled each cycle.
- sw_o  output  Width  debounced level, active-high (1 = pressed).
- rise_o  output  Width  1-cycle pulse when the debounced bit goes 0->1 (press).
- fall_o  output  Width  1-cycle pulse when the debounced bit goes 1->0 (release).
- status_o  output  Width  sticky event flags.
- irq_o  output  1  registered OR of status_o.

Behaviour:
- Reset values (asynchronous, on rst_sys_ni low):
  - both synchroniser stages = all-ones (released);
  - stable = all-ones, so sw_o = 0;
  - counters = 0;
  - rise_o, fall_o, status_o = 0; irq_o = 0.
  - Releasing reset with switches released produces no edge.
- Synchroniser: two flops per bit. s2 is the second stage.
- Per-bit debounce, evaluated each cycle:
  - s2 == stable[i]: cnt[i] <= 0.
  - s2 != stable[i] and cnt[i] < DebounceCycles-1: cnt[i] <= cnt[i]+1.
  - s2 != stable[i] and cnt[i] == DebounceCycles-1: stable[i] <= s2, cnt[i] <= 0, and the edge pulse registers for the next cycle.
- A single mismatch-free sample restarts the count. Glitches shorter than DebounceCycles samples never reach sw_o.
- Counter never exceeds DebounceCycles-1. No wrap.
- sw_o = ~stable, driven directly from the register.
- Latency: a pin change held steady at cycle 0 first reaches s2 at cycle 2. stable flips at the edge ending cycle 2+DebounceCycles-1, so sw_o changes DebounceCycles+2 cycles after the pin.
- rise_o[i]/fall_o[i] assert in the same cycle sw_o[i] changes, for exactly one cycle.
- Bits are fully independent. Simultaneous edges on several bits all pulse in the same cycle.
- status[i] next value:
  - set if (rise_o[i] | fall_o[i]) & irq_en_i[i];
  - else cleared if clr_i[i];
  - else held.
  - Set wins over a same-cycle clear, so no event is lost.
- irq_en_i low masks setting only. It does not clear existing status.
- irq_o <= |status_o, i.e. one cycle after status_o.
- Reset mid-debounce: the count is discarded, the bit returns to released, and there is no pulse. After reset, a held-pressed pin produces a full press sequence (rise pulse) DebounceCycles+2 cycles later.

Test Plan:
Bench runs with DebounceCycles=4, Width=13.
- Reset, sw_ni=all-ones held 20 cycles -> sw_o=0, no rise_o/fall_o pulses, irq_o=0 throughout.
- sw_ni[0] driven 0 at cycle 0 and held -> sw_o[0]=1 and rise_o[0] high for exactly one cycle at cycle 6. With irq_en_i[0]=1: status_o[0]=1 at cycle 7, irq_o=1 at cycle 8.
- Glitch: sw_ni[3] low for 3 cycles then high, repeated 10 times -> sw_o[3] stays 0, no pulses, counter returns to 0.
- Press then release sw_ni[12] with irq_en_i=0 -> rise_o[12], then fall_o[12] pulses. status_o stays 0 and irq_o stays 0.
- status_o[0]=1, clr_i[0]=1 in the same cycle as a new fall_o[0] with irq_en_i[0]=1 -> status_o[0] remains 1. clr_i[0] alone on the next cycle -> status_o[0]=0, then irq_o=0 one cycle later.
- sw_ni[5] held low; assert rst_sys_ni=0 at debounce cycle 2, release it -> sw_o[5]=0 during reset. After release, rise_o[5] fires 6 cycles later.

Source files
------------

// File: rtl/sonata_switch_debounce.sv
// rtl/sonata_switch_debounce.sv - switch synchroniser, debouncer, edge detector and sticky interrupt
//
// Ports:
//   clk_sys_i   system clock
//   rst_sys_ni  asynchronous active-low reset
//   sw_ni       raw active-low switch pins, asynchronous to clk_sys_i
//   irq_en_i    per-bit interrupt enable (masks setting of status only)
//   clr_i       per-bit write-1-to-clear of status, level-sampled every cycle
//   sw_o        debounced level, 1 = pressed
//   rise_o      one-cycle pulse on press
//   fall_o      one-cycle pulse on release
//   status_o    sticky event flags
//   irq_o       registered OR of status_o
module sonata_switch_debounce #(
    parameter int Width          = 13,
    parameter int DebounceCycles = 500000,
    parameter int CntWidth       = $clog2(DebounceCycles)
) (
    input  logic             clk_sys_i,
    input  logic             rst_sys_ni,
    input  logic [Width-1:0] sw_ni,
    input  logic [Width-1:0] irq_en_i,
    input  logic [Width-1:0] clr_i,
    output logic [Width-1:0] sw_o,
    output logic [Width-1:0] rise_o,
    output logic [Width-1:0] fall_o,
    output logic [Width-1:0] status_o,
    output logic             irq_o
);

    localparam logic [CntWidth-1:0] CntMax = CntWidth'(DebounceCycles - 1);

    logic [Width-1:0]    sync_q1;
    logic [Width-1:0]    sync_q2;
    logic [Width-1:0]    stable_q;
    logic [Width-1:0]    stable_d;
    logic [Width-1:0]    rise_q;
    logic [Width-1:0]    rise_d;
    logic [Width-1:0]    fall_q;
    logic [Width-1:0]    fall_d;
    logic [Width-1:0]    status_q;
    logic [Width-1:0]    status_d;
    logic                irq_q;
    logic [CntWidth-1:0] cnt_q [Width];
    logic [CntWidth-1:0] cnt_d [Width];

    // Per-bit consecutive-sample counter. stable_q holds the active-low
    // debounced level; it only follows sync_q2 after DebounceCycles
    // back-to-back mismatching samples, and any matching sample restarts it.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < Width; i++) begin
            if (sync_q2[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                stable_d[i] = sync_q2[i];
                cnt_d[i]    = '0;
                // Pin going low is a press because the switches are active-low.
                rise_d[i]   = ~sync_q2[i];
                fall_d[i]   = sync_q2[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CntWidth'(1);
            end
        end
    end

    // Setting takes priority over a same-cycle clear so no event is lost.
    always_comb begin
        status_d = ((rise_q | fall_q) & irq_en_i) | (status_q & ~clr_i);
    end

    always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
        if (!rst_sys_ni) begin
            sync_q1  <= '1;
            sync_q2  <= '1;
            stable_q <= '1;
            rise_q   <= '0;
            fall_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < Width; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_q1  <= sw_ni;
            sync_q2  <= sync_q1;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            status_q <= status_d;
            irq_q    <= |status_q;
            for (int i = 0; i < Width; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_o     = ~stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign status_o = status_q;
    assign irq_o    = irq_q;

endmodule
